snake_engine: RTL and testbench

- Parametrised snake game core. It replaces the fixed 15-segment snake controller.
- Holds a body of up to MAX_LEN tile segments on a GRID_W x GRID_H tile grid. It advances one step per TICK pulse, grows on apple capture and detects self-collision.
- It also answers per-pixel "is this snake?" queries from the VGA path.
- Sits between the master state machine, the navigation FSM, the apple generator and the colour mux.

---
 rtl/snake_engine.sv | 165 ++++++++++++++++
 tb/tb_snake_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// snake_engine: parametrised snake game core.
// Holds up to MAX_LEN tile segments and steps once per TICK while running.
// It grows on apple capture, detects self-collision and answers per-pixel
// head/body queries with one cycle of latency.
// Optional build macro SNAKE_WALL_KILL_EN: crossing a grid edge kills the
// snake instead of wrapping around.
module snake_engine #(
  parameter int MAX_LEN    = 32,
  parameter int INIT_LEN   = 5,
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int START_H    = 40,
  parameter int START_V    = 30,
  parameter int TILE_SHIFT = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       ENABLE,
  input  logic [1:0] DIR,
  input  logic [6:0] APPLE_H,
  input  logic [5:0] APPLE_V,
  input  logic       APPLE_VALID,
  input  logic [9:0] ADDRH,
  input  logic [8:0] ADDRV,
  output logic       PIX_HEAD,
  output logic       PIX_BODY,
  output logic [6:0] HEAD_H,
  output logic [5:0] HEAD_V,
  output logic [6:0] LENGTH,
  output logic       REACHED_TARGET,
  output logic       COLLISION,
  output logic [1:0] CUR_DIR
);

`ifdef SNAKE_WALL_KILL_EN
  localparam bit WALL_KILL = 1'b1;
`else
  localparam bit WALL_KILL = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] v;
  } seg_t;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t                 state, state_nxt;
  seg_t [MAX_LEN-1:0]     seg;
  logic [6:0]             len;
  logic [1:0]             cur_dir, nd;
  seg_t                   nxt;
  logic                   wall, eat, grow, hit, step, die, advance;
  logic                   rt;
  logic                   pix_head, pix_body, ph_d, pb_d;
  logic [9:0]             th;
  logic [8:0]             tv;

  // Straight horizontal line ending at START_H, wrapped into the grid.
  function automatic seg_t [MAX_LEN-1:0] init_body();
    seg_t [MAX_LEN-1:0] b;
    int h;
    for (int i = 0; i < MAX_LEN; i++) begin
      h = (START_H - i) % GRID_W;
      if (h < 0) h = h + GRID_W;
      b[i].h = 7'(h);
      b[i].v = 6'(START_V);
    end
    return b;
  endfunction

  // Applied direction (reversals ignored) and the next head with wrap.
  always_comb begin
    nd   = (DIR == ~cur_dir) ? cur_dir : DIR;
    nxt  = seg[0];
    wall = 1'b0;
    case (nd)
      2'b00: if (seg[0].h == 7'(GRID_W-1)) begin nxt.h = '0; wall = 1'b1; end
             else nxt.h = seg[0].h + 7'd1;
      2'b01: if (seg[0].v == 6'(GRID_H-1)) begin nxt.v = '0; wall = 1'b1; end
             else nxt.v = seg[0].v + 6'd1;
      2'b10: if (seg[0].v == '0) begin nxt.v = 6'(GRID_H-1); wall = 1'b1; end
             else nxt.v = seg[0].v - 6'd1;
      default: if (seg[0].h == '0) begin nxt.h = 7'(GRID_W-1); wall = 1'b1; end
               else nxt.h = seg[0].h - 7'd1;
    endcase
  end

  // Apple capture and self-collision; the tail counts only when growing.
  always_comb begin
    eat  = APPLE_VALID && (nxt.h == APPLE_H) && (nxt.v == APPLE_V);
    grow = eat && (len < 7'(MAX_LEN));
    hit  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((seg[i] == nxt) && ((i + 1 < int'(len)) || (grow && i < int'(len))))
        hit = 1'b1;
    step    = (state == RUN) && TICK;
    die     = step && (hit || (WALL_KILL && wall));
    advance = step && !die;
  end

  // Pixel query: tile lookup against head and live body segments.
  always_comb begin
    th   = ADDRH >> TILE_SHIFT;
    tv   = ADDRV >> TILE_SHIFT;
    ph_d = 1'b0;
    pb_d = 1'b0;
    if (th < 10'(GRID_W) && tv < 9'(GRID_H)) begin
      ph_d = (th == 10'(seg[0].h)) && (tv == 9'(seg[0].v));
      for (int i = 1; i < MAX_LEN; i++)
        if (i < int'(len) && th == 10'(seg[i].h) && tv == 9'(seg[i].v))
          pb_d = 1'b1;
    end
  end

  // FSM state register; ENABLE low restarts from any state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    if (!ENABLE) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     if (die) state_nxt = DEAD;
        default: state_nxt = DEAD;
      endcase
    end
  end

  // Body shift, length, direction, apple pulse and pixel registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      seg <= init_body(); len <= 7'(INIT_LEN); cur_dir <= 2'b00;
      rt <= 1'b0; pix_head <= 1'b0; pix_body <= 1'b0;
    end else if (!ENABLE) begin
      seg <= init_body(); len <= 7'(INIT_LEN); cur_dir <= 2'b00;
      rt <= 1'b0; pix_head <= 1'b0; pix_body <= 1'b0;
    end else begin
      rt       <= advance && eat;
      pix_head <= ph_d;
      pix_body <= pb_d && !ph_d;
      if (step) cur_dir <= nd;
      if (advance) begin
        seg <= {seg[MAX_LEN-2:0], nxt};
        if (grow) len <= len + 7'd1;
      end
    end
  end

  assign HEAD_H         = seg[0].h;
  assign HEAD_V         = seg[0].v;
  assign LENGTH         = len;
  assign CUR_DIR        = cur_dir;
  assign REACHED_TARGET = rt;
  assign COLLISION      = (state == DEAD);
  assign PIX_HEAD       = pix_head;
  assign PIX_BODY       = pix_body;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed and randomized checks of snake_engine against a
// queue-based model of the snake body.
module tb_snake_engine;
  localparam int MAX_LEN = 32, INIT_LEN = 5, GRID_W = 80, GRID_H = 60;
  localparam int START_H = 40, START_V = 30, TILE_SHIFT = 3;
`ifdef SNAKE_WALL_KILL_EN
  localparam bit WK = 1'b1;
`else
  localparam bit WK = 1'b0;
`endif

  logic       CLK = 1'b0, RESET = 1'b0, TICK = 1'b0, ENABLE = 1'b0;
  logic [1:0] DIR = 2'b00;
  logic [6:0] APPLE_H = '0;
  logic [5:0] APPLE_V = '0;
  logic       APPLE_VALID = 1'b0;
  logic [9:0] ADDRH = '0;
  logic [8:0] ADDRV = '0;
  logic       PIX_HEAD, PIX_BODY, REACHED_TARGET, COLLISION;
  logic [6:0] HEAD_H, LENGTH;
  logic [5:0] HEAD_V;
  logic [1:0] CUR_DIR;

  snake_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .GRID_W(GRID_W),
    .GRID_H(GRID_H), .START_H(START_H), .START_V(START_V),
    .TILE_SHIFT(TILE_SHIFT)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .ENABLE(ENABLE), .DIR(DIR),
    .APPLE_H(APPLE_H), .APPLE_V(APPLE_V), .APPLE_VALID(APPLE_VALID),
    .ADDRH(ADDRH), .ADDRV(ADDRV), .PIX_HEAD(PIX_HEAD), .PIX_BODY(PIX_BODY),
    .HEAD_H(HEAD_H), .HEAD_V(HEAD_V), .LENGTH(LENGTH),
    .REACHED_TARGET(REACHED_TARGET), .COLLISION(COLLISION), .CUR_DIR(CUR_DIR));

  always #5 CLK = ~CLK;

  // Model: body as a queue of tiles, head first; state 0 idle, 1 run, 2 dead.
  int bh[$], bv[$];
  int mst, mdir, mrt, mph, mpb;
  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_restart();
    bh.delete(); bv.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      bh.push_back((START_H - i + GRID_W) % GRID_W);
      bv.push_back(START_V);
    end
    mst = 0; mdir = 0; mrt = 0;
  endtask

  function automatic int eff_dir(input int d);
    return (d == 3 - mdir) ? mdir : d;
  endfunction

  task automatic next_pos(input int d, output int h, output int v, output bit wall);
    h = bh[0] + ((d == 0) ? 1 : (d == 3) ? -1 : 0);
    v = bv[0] + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
    wall = (h < 0) || (h >= GRID_W) || (v < 0) || (v >= GRID_H);
    h = (h + GRID_W) % GRID_W;
    v = (v + GRID_H) % GRID_H;
  endtask

  task automatic check_all();
    check("head_h", 32'(HEAD_H), bh[0]);
    check("head_v", 32'(HEAD_V), bv[0]);
    check("length", 32'(LENGTH), bh.size());
    check("cur_dir", 32'(CUR_DIR), mdir);
    check("reached", 32'(REACHED_TARGET), mrt);
    check("collision", 32'(COLLISION), (mst == 2) ? 1 : 0);
    check("pix_head", 32'(PIX_HEAD), mph);
    check("pix_body", 32'(PIX_BODY), mpb);
  endtask

  // One clock: advance the model from pre-edge inputs, then compare.
  task automatic cycle();
    int nph = 0, npb = 0, nrt = 0, th, tv, d, h, v, limit;
    bit wall, eat, grow, hit;
    if (ENABLE) begin
      th = int'(ADDRH) >> TILE_SHIFT;
      tv = int'(ADDRV) >> TILE_SHIFT;
      if (th < GRID_W && tv < GRID_H)
        for (int k = 0; k < bh.size(); k++)
          if (bh[k] == th && bv[k] == tv) begin
            if (k == 0) nph = 1; else npb = 1;
          end
      if (nph) npb = 0;
      if (mst == 0) mst = 1;
      else if (mst == 1 && TICK) begin
        d = eff_dir(int'(DIR));
        next_pos(d, h, v, wall);
        eat   = APPLE_VALID && h == int'(APPLE_H) && v == int'(APPLE_V);
        grow  = eat && bh.size() < MAX_LEN;
        limit = grow ? bh.size() : bh.size() - 1;
        hit   = 1'b0;
        for (int k = 0; k < limit; k++)
          if (bh[k] == h && bv[k] == v) hit = 1'b1;
        mdir = d;
        if (hit || (WK && wall)) mst = 2;
        else begin
          bh.push_front(h); bv.push_front(v);
          if (!grow) begin void'(bh.pop_back()); void'(bv.pop_back()); end
          nrt = eat;
        end
      end
    end else m_restart();
    mph = nph; mpb = npb; mrt = nrt;
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic tick(input int d, input bit apple);
    int h, v;
    bit wall;
    DIR = 2'(d);
    TICK = 1'b1;
    APPLE_VALID = apple;
    if (apple) begin
      next_pos(eff_dir(d), h, v, wall);
      APPLE_H = 7'(h); APPLE_V = 6'(v);
    end
    cycle();
    TICK = 1'b0;
    APPLE_VALID = 1'b0;
  endtask

  task automatic query(input int h, input int v);
    ADDRH = 10'(h * 8 + 3);
    ADDRV = 9'(v * 8 + 5);
  endtask

  initial begin
    int k;
    // Reset state
    m_restart(); mph = 0; mpb = 0;
    #12;
    check_all();
    @(negedge CLK);
    RESET = 1'b1;
    ENABLE = 1'b1;

    // Pixel queries around the start layout (IDLE -> RUN on this edge)
    ADDRH = 10'd323; ADDRV = 9'd243;
    cycle(); check("pix_head_323", 32'(PIX_HEAD), 1);
    ADDRH = 10'd315;
    cycle(); check("pix_body_315", 32'(PIX_BODY), 1); check("pix_head_315", 32'(PIX_HEAD), 0);
    ADDRH = 10'd1000; cycle();
    ADDRH = 10'd323; ADDRV = 9'd500; cycle();

    // Three steps right
    for (int i = 0; i < 3; i++) tick(0, 0);
    check("head_43", 32'(HEAD_H), 43); check("len_5", 32'(LENGTH), 5);
    query(39, 30); cycle(); check("tail_39", 32'(PIX_BODY), 1);
    query(38, 30); cycle(); check("vacated_38", 32'(PIX_BODY), 0);

    // Apple capture from the start position
    ENABLE = 1'b0; cycle(); ENABLE = 1'b1; cycle();
    tick(0, 1);
    check("eat_pulse", 32'(REACHED_TARGET), 1); check("len_6", 32'(LENGTH), 6);
    query(36, 30); cycle(); check("eat_pulse_off", 32'(REACHED_TARGET), 0);
    check("tail_kept", 32'(PIX_BODY), 1);

    // Reversal is ignored
    tick(3, 0);
    check("rev_dir", 32'(CUR_DIR), 0); check("rev_head", 32'(HEAD_H), 42);

    // Self-collision: down, left, up
    ENABLE = 1'b0; cycle(); ENABLE = 1'b1; cycle();
    tick(1, 0); tick(3, 0); tick(2, 0);
    check("dead", 32'(COLLISION), 1); check("dead_len", 32'(LENGTH), 5);
    tick(0, 1);
    check("frozen_h", 32'(HEAD_H), 39); check("frozen_v", 32'(HEAD_V), 31);
    ENABLE = 1'b0; cycle();
    check("restart_col", 32'(COLLISION), 0); check("restart_h", 32'(HEAD_H), 40);
    ENABLE = 1'b1; cycle();

    // Horizontal edge, then vertical edge
    for (int i = 0; i < 39; i++) tick(0, 0);
    check("at_79", 32'(HEAD_H), 79);
    tick(0, 0);
`ifdef SNAKE_WALL_KILL_EN
    check("wall_dead", 32'(COLLISION), 1); check("wall_stay", 32'(HEAD_H), 79);
`else
    check("wrap_0", 32'(HEAD_H), 0);
`endif
    for (int i = 0; i < 31; i++) tick(2, 0);

    // Grow to MAX_LEN, then eat without growing
    ENABLE = 1'b0; cycle(); ENABLE = 1'b1; cycle();
    for (int i = 0; i < 30; i++) tick(0, 1);
    check("max_len", 32'(LENGTH), MAX_LEN); check("max_eat", 32'(REACHED_TARGET), 1);

    // Randomized play
    for (int i = 0; i < 1500; i++) begin
      if (mst == 2 && $urandom_range(3) == 0) ENABLE = 1'b0;
      else ENABLE = ($urandom_range(49) != 0);
      if ($urandom_range(1) == 0) begin
        k = $urandom_range(bh.size() - 1);
        ADDRH = 10'(bh[k] * 8 + $urandom_range(7));
        ADDRV = 9'(bv[k] * 8 + $urandom_range(7));
      end else begin
        ADDRH = 10'($urandom); ADDRV = 9'($urandom);
      end
      if ($urandom_range(1) == 0) begin
        tick($urandom_range(3), $urandom_range(2) == 0);
      end else begin
        DIR = 2'($urandom); APPLE_H = 7'($urandom); APPLE_V = 6'($urandom);
        APPLE_VALID = 1'($urandom);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
